imem_uart_loader: RTL and testbench

//  Boot-time instruction loader upstream of top's instruction memory (imem.RAM): replaces
//  $readmemh on hardware. Parses a framed byte stream from the UART receiver, writes 32-bit

---
 rtl/imem_uart_loader.sv | 187 ++++++++++++++++++
 tb/tb_imem_uart_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_uart_loader.sv
// Boot loader: parses SYNC/LEN/data/CSUM byte frames into imem word writes and holds the core in reset until a frame checks out.
// Latency: write pulse 1 clk after a word's 4th byte; no backpressure, a byte may arrive every cycle.
module imem_uart_loader #(
    parameter int unsigned ADDR_W    = 6,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       shift_q, shift_d;
    logic [7:0]        csum_q, csum_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              in_frame;
    logic [15:0]       len_full;
    logic [31:0]       word;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        csum_d     = csum_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cpu_rst_d  = cpu_rst_q;
        done_d     = done_q;
        err_d      = err_q;

        in_frame = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                   (state_q == S_DATA) || (state_q == S_CSUM);
        len_full = {rx_data, len_q[7:0]};
        // Three buffered bytes plus the arriving one form the little-endian word.
        word     = {rx_data, shift_q};

        tmo_d = '0;
        if (in_frame && !rx_valid) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d    = S_LEN0;
                    cpu_rst_d  = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    csum_d     = '0;
                    idx_d      = '0;
                    byte_cnt_d = '0;
                    shift_d    = '0;
                end
            end
            S_LEN0: begin
                if (rx_valid) begin
                    len_d   = {8'h00, rx_data};
                    csum_d  = csum_q ^ rx_data;
                    state_d = S_LEN1;
                end
            end
            S_LEN1: begin
                if (rx_valid) begin
                    len_d  = len_full;
                    csum_d = csum_q ^ rx_data;
                    if ({1'b0, len_full} > DEPTH) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else if (len_full == 16'h0000) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    csum_d     = csum_q ^ rx_data;
                    shift_d    = word[31:8];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = idx_q;
                        wdata_d = word;
                        idx_d   = idx_q + ADDR_W'(1);
                        if (16'(idx_q) == len_q - 16'd1) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == csum_q) begin
                        state_d   = S_DONE;
                        cpu_rst_d = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A stalled sender abandons the frame; any partial word is simply never written.
        if (in_frame && !rx_valid && tmo_q == TMO_W'(TIMEOUT - 1)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            csum_q     <= '0;
            tmo_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            csum_q     <= csum_d;
            tmo_q      <= tmo_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_reset  = cpu_rst_q;
    assign load_done  = done_q;
    assign load_error = err_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: frame table plus hand sequences for timeout, idle bytes and mid-frame reset.
// Expected writes are queued as frames are sent and matched against each imem_we pulse.
module tb_imem_uart_loader;

    localparam int ADDR_W  = 6;
    localparam int TIMEOUT = 64;
    localparam int DEPTH   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              load_done;
    logic              load_error;

    imem_uart_loader #(
        .ADDR_W   (ADDR_W),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_reset (cpu_reset),
        .load_done (load_done),
        .load_error(load_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int                cyc;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        int len;
        int src;       // 0: fixed program words, 1: random, 2: all SYNC bytes
        bit bad;
        bit b2b;
        bit exp_done;
        bit exp_err;
        bit exp_cpu_rst;
    } vec_t;
    vec_t vecs[10];

    logic [31:0]       fixed_words[2];
    logic [ADDR_W-1:0] last_addr = '0;
    logic [31:0]       last_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        wr_t e;
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(imem_addr), 32'(e.addr));
                check("write_data", imem_wdata, e.data);
                check("write_cycle", cyc, e.cyc);
            end
        end
    end

    // Always entered and left at 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input int len, input int src, input bit bad, input bit b2b);
        logic [15:0] l16;
        logic [7:0]  cs;
        logic [7:0]  b;
        logic [31:0] w;
        l16 = len[15:0];
        send_byte(8'hA5, !b2b);
        send_byte(l16[7:0], !b2b);
        cs = l16[7:0];
        cs ^= l16[15:8];
        if (len > DEPTH) begin
            send_byte(l16[15:8], 1'b0);
            return;
        end
        send_byte(l16[15:8], !b2b);
        for (int i = 0; i < len; i++) begin
            case (src)
                0:       w = fixed_words[i];
                2:       w = 32'hA5A5_A5A5;
                default: w = $urandom;
            endcase
            for (int k = 0; k < 4; k++) begin
                b = w[8*k +: 8];
                cs ^= b;
                if (k == 3) begin
                    exp_q.push_back('{addr: i[ADDR_W-1:0], data: w, cyc: cyc + 1});
                    last_addr = i[ADDR_W-1:0];
                    last_data = w;
                end
                send_byte(b, !b2b);
            end
        end
        send_byte(bad ? (cs ^ 8'hFF) : cs, 1'b0);
    endtask

    // Samples the first cycle after the frame's final strobe.
    task automatic post_check(input string tag, input bit d, input bit e, input bit c);
        @(negedge clk);
        check({tag, "_load_done"},  32'(load_done),  32'(d));
        check({tag, "_load_error"}, 32'(load_error), 32'(e));
        check({tag, "_cpu_reset"},  32'(cpu_reset),  32'(c));
        check({tag, "_writes_left"}, exp_q.size(), 0);
        check({tag, "_addr_hold"},  32'(imem_addr),  32'(last_addr));
        check({tag, "_wdata_hold"}, imem_wdata,      last_data);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin : main
        fixed_words[0] = 32'h0190_0513;
        fixed_words[1] = 32'h00A0_05B3;
        //           len     src bad b2b done err cpu_rst
        vecs[0] = '{2,       0,  0,  0,  1,   0,  0};
        vecs[1] = '{2,       0,  1,  0,  0,   1,  1};
        vecs[2] = '{2,       0,  0,  1,  1,   0,  0};
        vecs[3] = '{'h41,    0,  0,  0,  0,   1,  1};
        vecs[4] = '{0,       0,  0,  0,  1,   0,  0};
        vecs[5] = '{21,      1,  0,  1,  1,   0,  0};
        vecs[6] = '{64,      1,  0,  1,  1,   0,  0};
        vecs[7] = '{1,       2,  1,  0,  0,   1,  1};
        vecs[8] = '{1,       2,  0,  0,  1,   0,  0};
        vecs[9] = '{'hFFFF,  0,  0,  1,  0,   1,  1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_imem_we",      32'(imem_we),    0);
        check("rst_imem_addr",    32'(imem_addr),  0);
        check("rst_imem_wdata",   imem_wdata,      0);
        check("rst_cpu_reset",    32'(cpu_reset),  1);
        check("rst_load_done",    32'(load_done),  0);
        check("rst_load_error",   32'(load_error), 0);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("idle_cpu_reset",  32'(cpu_reset),  1);
        check("idle_load_done",  32'(load_done),  0);
        check("idle_load_error", 32'(load_error), 0);
        @(posedge clk); #1;

        for (int r = 0; r < 10; r++) begin
            send_frame(vecs[r].len, vecs[r].src, vecs[r].bad, vecs[r].b2b);
            post_check($sformatf("row%0d", r), vecs[r].exp_done, vecs[r].exp_err, vecs[r].exp_cpu_rst);
        end

        // Stall after two data bytes of a one-word frame.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h05, 1'b0);
        repeat (TIMEOUT - 2) @(posedge clk);
        @(negedge clk);
        check("tmo_not_yet", 32'(load_error), 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("tmo_load_error", 32'(load_error), 1);
        check("tmo_cpu_reset",  32'(cpu_reset),  1);
        check("tmo_load_done",  32'(load_done),  0);
        @(posedge clk); #1;

        send_byte(8'h13, 1'b0);
        @(negedge clk);
        check("err_ignores_byte", 32'(load_error), 1);
        @(posedge clk); #1;

        send_frame(2, 0, 1'b0, 1'b0);
        post_check("reload", 1'b1, 1'b0, 1'b0);

        send_byte(8'h00, 1'b0);
        @(negedge clk);
        check("done_ignores_byte_done", 32'(load_done), 1);
        check("done_ignores_byte_rst",  32'(cpu_reset), 0);
        @(posedge clk); #1;

        // Reset lands while the fourth byte of word 0 is on the bus.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        rx_valid = 1'b1;
        rx_data  = 8'h44;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_imem_we",    32'(imem_we),    0);
        check("midrst_imem_addr",  32'(imem_addr),  0);
        check("midrst_imem_wdata", imem_wdata,      0);
        check("midrst_cpu_reset",  32'(cpu_reset),  1);
        check("midrst_load_done",  32'(load_done),  0);
        check("midrst_load_error", 32'(load_error), 0);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("postrst_cpu_reset", 32'(cpu_reset), 1);
        check("postrst_load_done", 32'(load_done), 0);
        last_addr = '0;
        last_data = '0;
        @(posedge clk); #1;

        send_frame(2, 0, 1'b0, 1'b1);
        post_check("recover", 1'b1, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("final_writes_left", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
